// File: rtl/keypad_time_entry_pkg.sv
// Shared definitions for the alarm-clock keypad time entry block.
//   - Time limits used when validating a committed HH:MM entry.
//   - BCD digit width, keypad size and entry buffer depth.
//   - Key FSM state encoding.
//   - Helpers: one-hot key vector to digit, BCD digit pair to binary.
package keypad_time_entry_pkg;

    localparam int unsigned MAX_HOURS   = 23;
    localparam int unsigned MAX_MINUTES = 59;
    localparam int unsigned BCD_WIDTH   = 4;
    localparam int unsigned NUM_KEYS    = 10;
    localparam int unsigned MAX_DIGITS  = 4;

    typedef enum logic {
        StWaitKey     = 1'b0,
        StWaitRelease = 1'b1
    } key_state_e;

    // Index of the set bit; only meaningful for a one-hot vector.
    function automatic logic [BCD_WIDTH-1:0] key_to_digit(input logic [NUM_KEYS-1:0] keys);
        logic [BCD_WIDTH-1:0] digit;
        digit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[k]) digit = BCD_WIDTH'(k);
        end
        return digit;
    endfunction

    // Two BCD digits (each 0..9) to a binary value 0..99.
    function automatic logic [6:0] bcd_pair_to_bin(input logic [BCD_WIDTH-1:0] tens,
                                                   input logic [BCD_WIDTH-1:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/keypad_time_entry_debounce.sv
// Keypad synchroniser and debouncer.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   keys_async   : raw key lines, asynchronous to clk
//   stable_keys  : synchronised key vector
//   stable_valid : stable_keys has been unchanged for DebounceCycles cycles
module keypad_time_entry_debounce #(
    parameter int unsigned DebounceCycles = 4,
    parameter int unsigned Width          = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] keys_async,
    output logic [Width-1:0] stable_keys,
    output logic             stable_valid
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);

    logic [Width-1:0] sync1_q, sync2_q, sync3_q;
    logic [CntW-1:0]  held_q, held_d;

    // held_d counts the cycles sync2_q has shown its current value, including this one;
    // a change seen against sync3_q restarts it at 1. Saturates at DebounceCycles.
    always_comb begin
        if (sync2_q != sync3_q) begin
            held_d = CntW'(1);
        end else if (held_q == CntW'(DebounceCycles)) begin
            held_d = held_q;
        end else begin
            held_d = held_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            held_q  <= '0;
        end else begin
            sync1_q <= keys_async;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            held_q  <= held_d;
        end
    end

    assign stable_keys  = sync2_q;
    assign stable_valid = (held_d == CntW'(DebounceCycles));

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: debounced digit keys build a BCD HH:MM buffer; the time or alarm
// button validates it and issues a one-cycle load strobe.
//   clk            : system clock (256 Hz), rising edge
//   reset          : asynchronous, active-low
//   keypad_buttons : one-hot digit keys 0..9, asynchronous
//   time_button    : commit entry as current time, asynchronous
//   alarm_button   : commit entry as alarm time, asynchronous
//   entry_digits   : BCD {H1,H0,M1,M0}
//   digit_count    : digits held, 0..4
//   entry_active   : digit_count != 0
//   load_hours     : committed hours, valid with load_time/load_alarm
//   load_minutes   : committed minutes, valid with load_time/load_alarm
//   load_time      : one-cycle strobe, load current time
//   load_alarm     : one-cycle strobe, load alarm time
//   entry_error    : one-cycle strobe, commit rejected
module keypad_time_entry
    import keypad_time_entry_pkg::*;
#(
    parameter int unsigned DebounceCycles = 4,
    parameter int unsigned TimeoutCycles  = 2560
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  keypad_buttons,
    input  logic        time_button,
    input  logic        alarm_button,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_count,
    output logic        entry_active,
    output logic [4:0]  load_hours,
    output logic [5:0]  load_minutes,
    output logic        load_time,
    output logic        load_alarm,
    output logic        entry_error
);

    localparam int unsigned IdleW = $clog2(TimeoutCycles + 1);

    logic [NUM_KEYS-1:0]  stable_keys;
    logic                 stable_valid;
    key_state_e           state_q;
    logic [1:0]           btn_sync1_q, btn_sync2_q, btn_sync3_q;  // {alarm, time}
    logic [IdleW-1:0]     idle_q;
    logic                 time_rise, alarm_rise, strobe_prev, commit, key_accept, entry_ok;
    logic [BCD_WIDTH-1:0] key_digit;
    logic [6:0]           hours_bin, minutes_bin;

    keypad_time_entry_debounce #(
        .DebounceCycles (DebounceCycles),
        .Width          (NUM_KEYS)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .keys_async   (keypad_buttons),
        .stable_keys  (stable_keys),
        .stable_valid (stable_valid)
    );

    assign time_rise   = btn_sync2_q[0] & ~btn_sync3_q[0];
    assign alarm_rise  = btn_sync2_q[1] & ~btn_sync3_q[1];
    // A strobe last cycle blocks a new commit so strobes never run back to back.
    assign strobe_prev = load_time | load_alarm | entry_error;
    assign commit      = (time_rise | alarm_rise) & ~strobe_prev;
    assign key_accept  = (state_q == StWaitKey) && stable_valid && $onehot(stable_keys);
    assign key_digit   = key_to_digit(stable_keys);

    // A partial entry is read as right-aligned: "435" is 04:35.
    assign hours_bin   = bcd_pair_to_bin(entry_digits[15:12], entry_digits[11:8]);
    assign minutes_bin = bcd_pair_to_bin(entry_digits[7:4], entry_digits[3:0]);
    assign entry_ok    = (digit_count != 3'd0) && (hours_bin <= 7'(MAX_HOURS))
                         && (minutes_bin <= 7'(MAX_MINUTES));

    assign entry_active = (digit_count != 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StWaitKey;
            btn_sync1_q  <= '0;
            btn_sync2_q  <= '0;
            btn_sync3_q  <= '0;
            idle_q       <= '0;
            entry_digits <= '0;
            digit_count  <= '0;
            load_hours   <= '0;
            load_minutes <= '0;
            load_time    <= 1'b0;
            load_alarm   <= 1'b0;
            entry_error  <= 1'b0;
        end else begin
            btn_sync1_q <= {alarm_button, time_button};
            btn_sync2_q <= btn_sync1_q;
            btn_sync3_q <= btn_sync2_q;

            unique case (state_q)
                StWaitKey:     if (key_accept) state_q <= StWaitRelease;
                StWaitRelease: if (stable_valid && stable_keys == '0) state_q <= StWaitKey;
                default:       state_q <= StWaitKey;
            endcase

            load_time    <= 1'b0;
            load_alarm   <= 1'b0;
            entry_error  <= 1'b0;
            load_hours   <= '0;
            load_minutes <= '0;

            // Commit beats a same-cycle key accept; a key accept beats the timeout.
            if (commit) begin
                if ((time_rise && alarm_rise) || !entry_ok) begin
                    entry_error <= 1'b1;
                end else begin
                    load_time    <= time_rise;
                    load_alarm   <= alarm_rise;
                    load_hours   <= hours_bin[4:0];
                    load_minutes <= minutes_bin[5:0];
                end
                entry_digits <= '0;
                digit_count  <= '0;
                idle_q       <= '0;
            end else if (key_accept) begin
                if (digit_count < 3'(MAX_DIGITS)) begin
                    entry_digits <= {entry_digits[11:0], key_digit};
                    digit_count  <= digit_count + 3'd1;
                end
                idle_q <= '0;
            end else if (entry_active) begin
                if (idle_q == IdleW'(TimeoutCycles - 1)) begin
                    entry_digits <= '0;
                    digit_count  <= '0;
                    idle_q       <= '0;
                end else begin
                    idle_q <= idle_q + IdleW'(1);
                end
            end else begin
                idle_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry with hand-computed expectations.
module tb_keypad_time_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  keypad_buttons;
    logic        time_button;
    logic        alarm_button;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic        entry_active;
    logic [4:0]  load_hours;
    logic [5:0]  load_minutes;
    logic        load_time;
    logic        load_alarm;
    logic        entry_error;

    int checks = 0;
    int errors = 0;
    int strobe_seen = 0;

    keypad_time_entry #(
        .DebounceCycles (4),
        .TimeoutCycles  (2560)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .keypad_buttons (keypad_buttons),
        .time_button    (time_button),
        .alarm_button   (alarm_button),
        .entry_digits   (entry_digits),
        .digit_count    (digit_count),
        .entry_active   (entry_active),
        .load_hours     (load_hours),
        .load_minutes   (load_minutes),
        .load_time      (load_time),
        .load_alarm     (load_alarm),
        .entry_error    (entry_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_time | load_alarm | entry_error) strobe_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int hold = 10, input int gap = 10);
        keypad_buttons    = '0;
        keypad_buttons[k] = 1'b1;
        tick(hold);
        keypad_buttons = '0;
        tick(gap);
    endtask

    // Button edge -> strobe is visible after the third clock edge, for one cycle only.
    task automatic commit_and_check(input string tag, input logic t, input logic a,
                                    input logic exp_t, input logic exp_a, input logic exp_e,
                                    input int exp_h, input int exp_m);
        time_button  = t;
        alarm_button = a;
        tick(2);
        check({tag, "_early"}, {29'd0, load_time, load_alarm, entry_error}, 32'd0);
        tick(1);
        check({tag, "_load_time"}, {31'd0, load_time}, {31'd0, exp_t});
        check({tag, "_load_alarm"}, {31'd0, load_alarm}, {31'd0, exp_a});
        check({tag, "_entry_error"}, {31'd0, entry_error}, {31'd0, exp_e});
        if (exp_t || exp_a) begin
            check({tag, "_hours"}, {27'd0, load_hours}, exp_h);
            check({tag, "_minutes"}, {26'd0, load_minutes}, exp_m);
        end
        check({tag, "_cleared"}, {13'd0, digit_count, entry_digits}, 32'd0);
        tick(1);
        check({tag, "_one_cycle"}, {29'd0, load_time, load_alarm, entry_error}, 32'd0);
        time_button  = 1'b0;
        alarm_button = 1'b0;
        tick(3);
    endtask

    initial begin
        int seen;
        reset          = 1'b0;
        keypad_buttons = '0;
        time_button    = 1'b0;
        alarm_button   = 1'b0;

        // 1. Reset state, then a 2-cycle bounce is rejected.
        tick(3);
        check("reset_outputs", {entry_digits, digit_count, entry_active, load_time, load_alarm,
                                entry_error}, 32'd0);
        check("reset_load", {21'd0, load_hours, load_minutes}, 32'd0);
        reset = 1'b1;
        tick(2);
        press(5, 2, 10);
        check("bounce_rejected", {13'd0, digit_count, entry_digits}, 32'd0);

        // 2. Latency of the first key: accepted on the 6th edge after the input changes.
        keypad_buttons = 10'b00_0001_0000;
        tick(5);
        check("latency_before", {29'd0, digit_count}, 32'd0);
        tick(1);
        check("latency_count", {29'd0, digit_count}, 32'd1);
        check("latency_digits", {16'd0, entry_digits}, 32'h0004);
        check("latency_active", {31'd0, entry_active}, 32'd1);
        tick(4);
        keypad_buttons = '0;
        tick(10);
        press(3);
        press(5);
        check("e435_digits", {16'd0, entry_digits}, 32'h0435);
        check("e435_count", {29'd0, digit_count}, 32'd3);
        commit_and_check("c0435", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 35);

        // 3. Alarm 07:14, then 25:00 rejected.
        press(7);
        press(1);
        press(4);
        check("e714_digits", {16'd0, entry_digits}, 32'h0714);
        commit_and_check("c0714", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7, 14);
        press(2);
        press(5);
        press(0);
        press(0);
        check("e2500_digits", {16'd0, entry_digits}, 32'h2500);
        commit_and_check("c2500", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

        // 4. Fifth key ignored; multi-key ignored; long hold accepted once.
        press(1);
        press(2);
        press(3);
        press(4);
        press(5);
        check("full_digits", {16'd0, entry_digits}, 32'h1234);
        check("full_count", {29'd0, digit_count}, 32'd4);
        commit_and_check("c1234", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12, 34);
        keypad_buttons = 10'b00_1000_0100;
        tick(10);
        keypad_buttons = '0;
        tick(10);
        check("multikey_none", {29'd0, digit_count}, 32'd0);
        press(8, 50, 10);
        check("hold_once_count", {29'd0, digit_count}, 32'd1);
        check("hold_once_digits", {16'd0, entry_digits}, 32'h0008);

        // 5. Timeout: 9 accepted on edge 6 of its press; buffer clears 2560 edges later.
        seen = strobe_seen;
        press(9);
        check("pre_timeout", {13'd0, digit_count, entry_digits}, {13'd0, 3'd2, 16'h0089});
        tick(2480);
        check("timeout_not_yet", {29'd0, digit_count}, 32'd2);
        tick(100);
        check("timeout_cleared", {13'd0, digit_count, entry_digits}, 32'd0);
        check("timeout_active", {31'd0, entry_active}, 32'd0);
        check("timeout_no_strobe", strobe_seen, seen);
        press(0);
        press(9);
        press(3);
        press(0);
        check("e0930_digits", {16'd0, entry_digits}, 32'h0930);
        commit_and_check("cboth", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);

        // 6. Asynchronous reset in mid-entry, then a fresh first digit.
        press(1);
        press(2);
        check("mid_count", {29'd0, digit_count}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {entry_digits, digit_count, entry_active, load_time, load_alarm,
                              entry_error}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        press(6);
        check("after_reset_count", {29'd0, digit_count}, 32'd1);
        check("after_reset_digits", {16'd0, entry_digits}, 32'h0006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
